// File: rtl/fsm_shift_ctrl.sv
//==============================================================================
// Module      : fsm_shift_ctrl
// Description : Programmable shift-enable controller for the serial
//               configuration path. Issues a DEFAULT_LEN-cycle shift_ena burst
//               out of reset, then runs start-requested bursts of a runtime
//               length with a done pulse and abort support.
//               Optional feature macro: FSM_SHIFT_RETRIGGER_EN
//               (when defined, start during a burst reloads the count).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fsm_shift_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_LEN = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             shift_ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_DEFAULT_LEN = CNT_W'(DEFAULT_LEN);
  localparam logic             C_RST_SHIFT   = (DEFAULT_LEN > 0);
  localparam state_t           C_RST_STATE   = (DEFAULT_LEN > 0) ? ST_SHIFT : ST_IDLE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             shift_ena_q, shift_ena_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // State and count register; reset launches the post-reset burst.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= C_RST_STATE;
      count_q <= C_DEFAULT_LEN;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and next-count logic: abort beats start, start beats counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
`ifdef FSM_SHIFT_RETRIGGER_EN
        else if (start) begin
          if (len != '0) begin
            count_d = len;
          end else begin
            state_d = ST_DONE;
            count_d = '0;
          end
        end
`endif
        else if (count_q == C_ONE) begin
          // Last enabled cycle: the count never goes below one, so no wrap.
          state_d = ST_DONE;
          count_d = '0;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
      default: begin
        // IDLE, DONE and any unreachable encoding behave alike; abort is a no-op.
        if (start) begin
          if (len != '0) begin
            state_d = ST_SHIFT;
            count_d = len;
          end else begin
            // Zero-length burst still reports completion.
            state_d = ST_DONE;
            count_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end
    endcase
  end

  // Moore output decode from the next state so the outputs can be registered.
  always_comb begin
    shift_ena_d = (state_d == ST_SHIFT);
    busy_d      = (state_d == ST_SHIFT);
    done_d      = (state_d == ST_DONE);
    remaining_d = (state_d == ST_SHIFT) ? count_d : '0;
  end

  // Output registers, loaded with the decode of the reset state under reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_ena_q <= C_RST_SHIFT;
      busy_q      <= C_RST_SHIFT;
      done_q      <= 1'b0;
      remaining_q <= C_DEFAULT_LEN;
    end else begin
      shift_ena_q <= shift_ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  assign shift_ena = shift_ena_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_shift_ctrl.sv
//==============================================================================
// Module      : tb_fsm_shift_ctrl
// Description : Directed self-checking bench for fsm_shift_ctrl. A default
//               instance (CNT_W=8, DEFAULT_LEN=4) and a narrow instance
//               (CNT_W=4, DEFAULT_LEN=0) share one clock.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fsm_shift_ctrl;

  logic       clk;
  logic       resetn, start, abort;
  logic [7:0] len;
  logic       shift_ena, busy, done;
  logic [7:0] remaining;

  logic       resetn4, start4, abort4;
  logic [3:0] len4;
  logic       shift_ena4, busy4, done4;
  logic [3:0] remaining4;

  int n_pass  = 0;
  int n_total = 0;
  int n_shift;
  int guard;
  int exp_retrig;

  fsm_shift_ctrl #(.CNT_W(8), .DEFAULT_LEN(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .len(len), .abort(abort),
    .shift_ena(shift_ena), .busy(busy), .done(done), .remaining(remaining)
  );

  fsm_shift_ctrl #(.CNT_W(4), .DEFAULT_LEN(0)) dut4 (
    .clk(clk), .resetn(resetn4), .start(start4), .len(len4), .abort(abort4),
    .shift_ena(shift_ena4), .busy(busy4), .done(done4), .remaining(remaining4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Full output check of the default instance.
  task automatic chk_all(input string tag, input logic se, input logic dn, input logic [7:0] rem);
    chk({tag, ".shift_ena"}, 32'(shift_ena), 32'(se));
    chk({tag, ".busy"},      32'(busy),      32'(se));
    chk({tag, ".done"},      32'(done),      32'(dn));
    chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; len = 8'd0;
    resetn4 = 1'b0; start4 = 1'b0; abort4 = 1'b0; len4 = 4'd0;

    // Three reset cycles: post-reset burst held at its full length.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 1'b1, 1'b0, 8'd4);
    end
    chk("reset4.shift_ena", 32'(shift_ena4), 32'd0);
    chk("reset4.remaining", 32'(remaining4), 32'd0);
    resetn = 1'b1; resetn4 = 1'b1;

    // Release: count 3,2,1 follow the last reset cycle, then done, then idle.
    for (int r = 3; r >= 1; r--) begin
      tick();
      chk_all("post_reset", 1'b1, 1'b0, 8'(r));
    end
    tick(); chk_all("post_reset_done", 1'b0, 1'b1, 8'd0);
    tick(); chk_all("post_reset_idle", 1'b0, 1'b0, 8'd0);
    chk("idle4.done", 32'(done4), 32'd0);

    // Abort in IDLE has no effect.
    abort = 1'b1; tick(); abort = 1'b0;
    chk_all("abort_idle", 1'b0, 1'b0, 8'd0);

    // len=7 burst.
    start = 1'b1; len = 8'd7; tick(); start = 1'b0;
    chk_all("len7", 1'b1, 1'b0, 8'd7);
    for (int r = 6; r >= 1; r--) begin
      tick();
      chk_all("len7", 1'b1, 1'b0, 8'(r));
    end
    tick(); chk_all("len7_done", 1'b0, 1'b1, 8'd0);
    tick(); chk_all("len7_idle", 1'b0, 1'b0, 8'd0);

    // Zero-length burst, then a len=3 start in the DONE cycle.
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    chk_all("len0_done", 1'b0, 1'b1, 8'd0);
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    chk_all("b2b", 1'b1, 1'b0, 8'd3);
    tick(); chk_all("b2b", 1'b1, 1'b0, 8'd2);
    tick(); chk_all("b2b", 1'b1, 1'b0, 8'd1);
    tick(); chk_all("b2b_done", 1'b0, 1'b1, 8'd0);
    tick(); chk_all("b2b_idle", 1'b0, 1'b0, 8'd0);

    // len=10, abort raised during the 4th SHIFT cycle.
    start = 1'b1; len = 8'd10; tick(); start = 1'b0;
    chk_all("abort_c1", 1'b1, 1'b0, 8'd10);
    tick(); tick(); tick();
    chk_all("abort_c4", 1'b1, 1'b0, 8'd7);
    abort = 1'b1; tick(); abort = 1'b0;
    chk_all("abort", 1'b0, 1'b0, 8'd0);
    tick(); chk_all("abort_nodone", 1'b0, 1'b0, 8'd0);

    // Abort and start together in SHIFT: abort wins.
    start = 1'b1; len = 8'd5; tick(); start = 1'b0;
    chk_all("abst_c1", 1'b1, 1'b0, 8'd5);
    abort = 1'b1; start = 1'b1; len = 8'd9; tick(); abort = 1'b0; start = 1'b0;
    chk_all("abort_start", 1'b0, 1'b0, 8'd0);
    tick(); chk_all("abort_start_idle", 1'b0, 1'b0, 8'd0);

    // Start during SHIFT: ignored by default, reloads with retrigger.
    start = 1'b1; len = 8'd10; tick(); start = 1'b0;
    tick(); tick();
    chk_all("retrig_c3", 1'b1, 1'b0, 8'd8);
    start = 1'b1; len = 8'd5; n_shift = 3; guard = 0;
    tick(); start = 1'b0;
    while (shift_ena && guard < 40) begin
      n_shift++; guard++; tick();
    end
`ifdef FSM_SHIFT_RETRIGGER_EN
    exp_retrig = 8;
`else
    exp_retrig = 10;
`endif
    chk("retrig.shift_cycles", 32'(n_shift), 32'(exp_retrig));
    chk("retrig.done", 32'(done), 32'd1);
    tick(); chk_all("retrig_idle", 1'b0, 1'b0, 8'd0);

    // Reset mid-burst: discarded, post-reset burst restarts at 4.
    start = 1'b1; len = 8'd7; tick(); start = 1'b0;
    tick();
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk_all("mid_reset", 1'b1, 1'b0, 8'd4);
    for (int r = 3; r >= 1; r--) begin
      tick();
      chk_all("mid_reset_burst", 1'b1, 1'b0, 8'(r));
    end
    tick(); chk_all("mid_reset_done", 1'b0, 1'b1, 8'd0);

    // Narrow counter: len=15 runs 15 cycles with no wrap.
    start4 = 1'b1; len4 = 4'd15; tick(); start4 = 1'b0;
    chk("w4.remaining_first", 32'(remaining4), 32'd15);
    n_shift = 0; guard = 0;
    while (shift_ena4 && guard < 40) begin
      chk("w4.remaining", 32'(remaining4), 32'(15 - n_shift));
      n_shift++; guard++; tick();
    end
    chk("w4.shift_cycles", 32'(n_shift), 32'd15);
    chk("w4.done", 32'(done4), 32'd1);
    tick();
    chk("w4.idle_done", 32'(done4), 32'd0);
    chk("w4.idle_shift", 32'(shift_ena4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
